// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one 8N1 UART transmitter
// between NREQ byte-stream requesters, with burst-limit and stall-timeout release.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_ptr
);

  // Handshake: a byte moves on any cycle where valid & ready are both high.
  // Valid never depends on ready; once raised it is held with stable data
  // until accepted. The arbiter only forwards this handshake, it never buffers.

  localparam int IW = $clog2(NREQ);
  localparam int BW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam int SW = (STALL_TIMEOUT == 0) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_LAST = (STALL_TIMEOUT == 0) ? '0 : SW'(STALL_TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   gidx_inc;
  logic [IW:0]     cand;
  logic            sel_found;
  logic            accept;
  logic            burst_hit;
  logic            stall_hit;
  logic            release_now;

  // First valid requester scanning from ptr upward, wrapping at NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!sel_found && req_valid[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  assign gidx_inc = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    stall_d     = stall_q;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    accept      = 1'b0;
    burst_hit   = 1'b0;
    stall_hit   = 1'b0;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = LOCKED;
          grant_d = NREQ'(1) << sel_idx;
          gidx_d  = sel_idx;
        end
      end
      LOCKED: begin
        tx_valid  = req_valid[gidx_q];
        tx_data   = req_data[{gidx_q, 3'b000} +: 8];
        req_ready = grant_q & {NREQ{tx_ready}};
        accept    = tx_valid & tx_ready;
        burst_hit = (MAX_BURST != 0) && (burst_q == BURST_LAST);
        stall_hit = (STALL_TIMEOUT != 0) && (stall_q == STALL_LAST);
        // Counters saturate so a disabled limit never wraps into a false release.
        if (accept && (burst_q != '1)) burst_d = burst_q + BW'(1);
        if (req_valid[gidx_q])         stall_d = '0;
        else if (stall_q != '1)        stall_d = stall_q + SW'(1);
        release_now = (accept && (req_last[gidx_q] || burst_hit)) ||
                      (!req_valid[gidx_q] && stall_hit);
        if (release_now) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_inc;
          burst_d = '0;
          stall_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == LOCKED);
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester sources, transmitter model,
// accepted-byte log, per-scenario checking tasks and a final report.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int MAX_BURST = 16;
  localparam int STALL_TIMEOUT = 8;
  localparam int WTIME = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b1;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              dbg_state;
  logic [1:0]        dbg_ptr;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .STALL_TIMEOUT(STALL_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [8:0]      src_mem [NREQ][64];
  int              src_len [NREQ];
  int              src_pos [NREQ];
  logic [NREQ-1:0] acc = '0;
  logic            tx_acc = 1'b0;
  int              ready_mode = 0;
  int              wcnt = 0;
  logic [11:0]     obs_q[$];
  logic [11:0]     exp_q[$];
  int              gl_idx[$];
  int              gl_cyc[$];
  logic [NREQ-1:0] prev_grant = '0;
  logic [3:0]      gi;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  end

  // Monitor at negedge, requester/transmitter drive just after posedge.
  always begin
    @(negedge clk);
    acc = req_valid & req_ready;
    tx_acc = tx_valid & tx_ready;
    gi = 4'd0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) gi = 4'(i);
    if (tx_acc) obs_q.push_back({gi, tx_data});
    n_cmp += 3;
    if (!$onehot0(grant)) begin
      n_fail++; $display("FAIL inv_grant_onehot: grant=%b required one-hot or zero", grant);
    end
    if (!$onehot0(req_ready)) begin
      n_fail++; $display("FAIL inv_ready_onehot: req_ready=%b required at most one high", req_ready);
    end
    if (tx_valid && !busy) begin
      n_fail++; $display("FAIL inv_valid_busy: tx_valid=1 busy=%b required busy=1", busy);
    end
    if (grant != '0 && prev_grant == '0) begin
      gl_idx.push_back(int'(gi));
      gl_cyc.push_back(cyc);
    end
    prev_grant = grant;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) src_pos[i]++;
      if (src_pos[i] < src_len[i]) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
        req_last[i] = src_mem[i][src_pos[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'hxx;
        req_last[i] = 1'bx;
      end
    end
    if (tx_acc) wcnt = 0;
    else if (wcnt < WTIME*10) wcnt++;
    tx_ready = (ready_mode == 0) || (wcnt >= WTIME*10);
  end

  task automatic wait_neg;
    @(negedge clk);
    #2;
  endtask

  task automatic load_src(input int r, input int n, input logic [7:0] base, input logic last_end);
    for (int k = 0; k < n; k++) src_mem[r][k] = {(last_end && k == n-1), base + 8'(k)};
    src_len[r] = n;
    src_pos[r] = 0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    ready_mode = 0;
    wcnt = 0;
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    wait_neg();
    wait_neg();
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    gl_idx.delete();
    gl_cyc.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_neg();
    wait_neg();
    n_cmp += 6;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr); end
    rst = 1'b0;
  endtask

  task automatic test_single_message;
    apply_reset();
    load_src(2, 3, 8'h41, 1'b1);
    wait_neg();
    n_cmp += 2;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_arb_latency: tx_valid=%b want 0", tx_valid); end
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_pre_grant: got %b want 0000", grant); end
    wait_neg();
    n_cmp += 5;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_tx_valid: got %b want 1", tx_valid); end
    if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_byte0: got %h want 41", tx_data); end
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_neg();
    n_cmp++;
    if (tx_data !== 8'h42) begin n_fail++; $display("FAIL single_byte1: got %h want 42", tx_data); end
    wait_neg();
    n_cmp++;
    if (tx_data !== 8'h43) begin n_fail++; $display("FAIL single_byte2: got %h want 43", tx_data); end
    wait_neg();
    n_cmp += 4;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release_busy: got %b want 0", busy); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_release_valid: got %b want 0", tx_valid); end
    if (dbg_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", dbg_ptr); end
    exp_q = '{{4'd2, 8'h41}, {4'd2, 8'h42}, {4'd2, 8'h43}};
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_seq[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_round_robin;
    int want_idx[5];
    want_idx = '{0, 1, 2, 3, 0};
    apply_reset();
    load_src(0, 2, 8'h10, 1'b1);
    src_mem[0][0][8] = 1'b1;
    load_src(1, 1, 8'h20, 1'b1);
    load_src(2, 1, 8'h30, 1'b1);
    load_src(3, 1, 8'h40, 1'b1);
    for (int t = 0; t < 100; t++) begin
      wait_neg();
      if (obs_q.size() >= 5 && !busy) break;
    end
    exp_q = '{{4'd0, 8'h10}, {4'd1, 8'h20}, {4'd2, 8'h30}, {4'd3, 8'h40}, {4'd0, 8'h11}};
    n_cmp += 2;
    if (gl_idx.size() != 5) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d grants want 5", gl_idx.size());
    end
    if (obs_q.size() != 5) begin
      n_fail++; $display("FAIL rr_byte_count: got %0d bytes want 5", obs_q.size());
    end
    if (gl_idx.size() == 5 && obs_q.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        n_cmp += 2;
        if (gl_idx[k] != want_idx[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gl_idx[k], want_idx[k]); end
        if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
        if (k > 0) begin
          n_cmp++;
          if (gl_cyc[k] - gl_cyc[k-1] != 2) begin
            n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 2", k, gl_cyc[k] - gl_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_burst_limit;
    int want_idx[4];
    want_idx = '{1, 3, 1, 1};
    apply_reset();
    load_src(1, 40, 8'h00, 1'b0);
    load_src(3, 2, 8'hA0, 1'b1);
    for (int k = 0; k < 16; k++) exp_q.push_back({4'd1, 8'(k)});
    exp_q.push_back({4'd3, 8'hA0});
    exp_q.push_back({4'd3, 8'hA1});
    for (int k = 16; k < 40; k++) exp_q.push_back({4'd1, 8'(k)});
    for (int t = 0; t < 300; t++) begin
      wait_neg();
      if (obs_q.size() >= 42) break;
    end
    for (int t = 0; t < 12; t++) wait_neg();
    n_cmp += 3;
    if (obs_q.size() != 42) begin n_fail++; $display("FAIL burst_count: got %0d bytes want 42", obs_q.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_final_busy: got %b want 0", busy); end
    if (gl_idx.size() != 4) begin n_fail++; $display("FAIL burst_grants: got %0d want 4", gl_idx.size()); end
    if (gl_idx.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (gl_idx[k] != want_idx[k]) begin n_fail++; $display("FAIL burst_order[%0d]: got %0d want %0d", k, gl_idx[k], want_idx[k]); end
      end
    end
    if (obs_q.size() == 42) begin
      for (int k = 0; k < 42; k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL burst_seq[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_stall_timeout;
    bit seen;
    seen = 1'b0;
    apply_reset();
    load_src(0, 1, 8'h55, 1'b0);
    load_src(1, 1, 8'h66, 1'b1);
    for (int t = 0; t < 20; t++) begin
      wait_neg();
      if (tx_valid && tx_ready && grant == 4'b0001) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL stall_first_byte: got no accept from req 0 want one within 20 cycles");
    end else begin
      n_cmp++;
      if (tx_data !== 8'h55) begin n_fail++; $display("FAIL stall_byte: got %h want 55", tx_data); end
      for (int k = 1; k <= 8; k++) begin
        wait_neg();
        n_cmp++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL stall_hold[%0d]: grant=%b want 0001", k, grant); end
      end
      wait_neg();
      n_cmp++;
      if (grant !== 4'b0000) begin n_fail++; $display("FAIL stall_release: grant=%b want 0000", grant); end
      wait_neg();
      n_cmp += 3;
      if (grant !== 4'b0010) begin n_fail++; $display("FAIL stall_next_grant: got %b want 0010", grant); end
      if (tx_data !== 8'h66) begin n_fail++; $display("FAIL stall_next_data: got %h want 66", tx_data); end
      if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_next_ready: got %b want 0010", req_ready); end
    end
  endtask

  task automatic test_slow_transmitter;
    logic [NREQ-1:0] want_rdy;
    apply_reset();
    ready_mode = 1;
    load_src(0, 3, 8'hC0, 1'b1);
    load_src(2, 2, 8'hD0, 1'b1);
    load_src(3, 2, 8'hE0, 1'b1);
    exp_q = '{{4'd0, 8'hC0}, {4'd0, 8'hC1}, {4'd0, 8'hC2}, {4'd2, 8'hD0}, {4'd2, 8'hD1},
              {4'd3, 8'hE0}, {4'd3, 8'hE1}};
    for (int t = 0; t < 600; t++) begin
      wait_neg();
      want_rdy = grant & {NREQ{tx_ready}};
      n_cmp++;
      if (req_ready !== want_rdy) begin
        n_fail++; $display("FAIL slow_ready_mirror: got %b want %b", req_ready, want_rdy);
      end
      if (obs_q.size() >= 7 && !busy) break;
    end
    n_cmp++;
    if (obs_q.size() != 7) begin
      n_fail++; $display("FAIL slow_count: got %0d bytes want 7", obs_q.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL slow_seq[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid_message;
    apply_reset();
    load_src(0, 1, 8'h77, 1'b1);
    load_src(1, 20, 8'h00, 1'b0);
    for (int t = 0; t < 50; t++) begin
      wait_neg();
      if (obs_q.size() >= 6) break;
    end
    n_cmp += 3;
    if (obs_q.size() < 6) begin n_fail++; $display("FAIL midrst_progress: got %0d bytes want 6", obs_q.size()); end
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL midrst_locked: grant=%b want 0010", grant); end
    if (dbg_ptr !== 2'd1) begin n_fail++; $display("FAIL midrst_pre_ptr: got %0d want 1", dbg_ptr); end
    rst = 1'b1;
    load_src(0, 1, 8'h88, 1'b1);
    wait_neg();
    n_cmp += 5;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL midrst_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_req_ready: got %b want 0000", req_ready); end
    if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL midrst_ptr: got %0d want 0", dbg_ptr); end
    rst = 1'b0;
    wait_neg();
    n_cmp += 2;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_regrant: got %b want 0001", grant); end
    if (tx_data !== 8'h88) begin n_fail++; $display("FAIL midrst_regrant_data: got %h want 88", tx_data); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_message();
    test_round_robin();
    test_burst_limit();
    test_stall_timeout();
    test_slow_transmitter();
    test_reset_mid_message();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
